// File: rtl/count_cmd_pkg.sv
// Shared definitions for the counter command driver.
// State encodings, default widths and the fixed strobe-to-check latency.
package count_cmd_pkg;

    localparam int DEFAULT_WIDTH  = 4;
    localparam int DEFAULT_GAP_W  = 4;

    // latch/dec strobe -> SETTLE -> CHECK
    localparam int STROBE_LATENCY = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_GAP    = 3'd4,
        ST_DEC    = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_e;

endpackage

// File: rtl/gap_timer.sv
// Loadable down-counter that times the idle gap between dec iterations.
// expire_o is high while the count is 1, i.e. in the last gap cycle.
module gap_timer #(
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [GAP_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_o
);

    logic [GAP_W-1:0] cnt_q;
    logic [GAP_W-1:0] cnt_d;

    // Next count: load has priority, otherwise count down while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - GAP_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == GAP_W'(1));

endmodule

// File: rtl/count_cmd_driver.sv
// Command-side driver for a loadable down-counter: latches a value, then
// issues dec strobes (with an optional idle gap) until the counter reports
// zero, and pulses done.
// Optional feature macro: CMD_OVERRUN_CHECK_EN (dec count overrun -> err pulse).
module count_cmd_driver
    import count_cmd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int GAP_W = DEFAULT_GAP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_vld,
    output logic             start_rdy,
    input  logic [WIDTH-1:0] start_val,
    input  logic [GAP_W-1:0] start_gap,
    output logic [WIDTH-1:0] IN,
    output logic             latch,
    output logic             dec,
    input  logic             zero,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] val_q;
    logic [GAP_W-1:0] gap_q;
    logic             latch_q;
    logic             dec_q;
    logic             done_q;
    logic             busy_q;
    logic             rdy_q;
    logic             transfer_s;
    logic             gap_load_s;
    logic             gap_en_s;
    logic             gap_expire_s;
    logic             overrun_s;

    assign transfer_s = start_vld && (state_q == ST_IDLE);

    gap_timer #(
        .GAP_W(GAP_W)
    ) u_gap_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (gap_load_s),
        .load_val_i(gap_q),
        .en_i      (gap_en_s),
        .expire_o  (gap_expire_s)
    );

`ifdef CMD_OVERRUN_CHECK_EN
    logic [WIDTH-1:0] dec_cnt_q;
    logic [WIDTH-1:0] dec_cnt_d;
    logic             err_q;

    // Dec counter: cleared on LOAD, bumped once per DEC cycle.
    always_comb begin
        dec_cnt_d = dec_cnt_q;
        if (state_q == ST_LOAD) begin
            dec_cnt_d = '0;
        end else if (state_q == ST_DEC) begin
            dec_cnt_d = dec_cnt_q + WIDTH'(1);
        end else begin
            dec_cnt_d = dec_cnt_q;
        end
    end

    // Dec counter and err strobe registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            dec_cnt_q <= dec_cnt_d;
            err_q     <= (state_d == ST_ERR);
        end
    end

    // All requested decrements issued yet the counter still is not zero.
    assign overrun_s = (dec_cnt_q == val_q);
    assign err       = err_q;
`else
    assign overrun_s = 1'b0;
    assign err       = 1'b0;
`endif

    // Next-state logic and gap timer control.
    always_comb begin
        state_d    = state_q;
        gap_load_s = 1'b0;
        gap_en_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_vld) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD:   state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_CHECK;
            ST_CHECK: begin
                if (zero) begin
                    state_d = ST_DONE;
                end else if (overrun_s) begin
                    state_d = ST_ERR;
                end else if (gap_q == '0) begin
                    state_d = ST_DEC;
                end else begin
                    gap_load_s = 1'b1;
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                gap_en_s = 1'b1;
                if (gap_expire_s) begin
                    state_d = ST_DEC;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_DEC:  state_d = ST_SETTLE;
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the request fields on the handshake edge; IN follows val_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= '0;
            gap_q <= '0;
        end else if (transfer_s) begin
            val_q <= start_val;
            gap_q <= start_gap;
        end else begin
            val_q <= val_q;
            gap_q <= gap_q;
        end
    end

    // Registered strobes and status, decoded from the upcoming state so they
    // line up with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch_q <= 1'b0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            latch_q <= (state_d == ST_LOAD);
            dec_q   <= (state_d == ST_DEC);
            done_q  <= (state_d == ST_DONE);
            busy_q  <= (state_d != ST_IDLE);
            rdy_q   <= (state_d == ST_IDLE);
        end
    end

    assign IN        = val_q;
    assign latch     = latch_q;
    assign dec       = dec_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign start_rdy = rdy_q;

endmodule

// File: tb/tb_count_cmd_driver.sv
// Self-checking bench for count_cmd_driver with a behavioural down-counter.
// Expected strobe timing comes from the command schedule:
// latch in cycle 1, dec in cycles 1+k*(G+3) for k=1..N, done in 4+N*(G+3).
module tb_count_cmd_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_vld = 1'b0;
    logic       start_rdy;
    logic [3:0] start_val = 4'd0;
    logic [3:0] start_gap = 4'd0;
    logic [3:0] IN;
    logic       latch;
    logic       dec;
    logic       zero;
    logic       busy;
    logic       done;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] ctr_q;
    logic       stuck = 1'b0;

    always #5 clk = ~clk;

    count_cmd_driver #(.WIDTH(4), .GAP_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_vld(start_vld),
        .start_rdy(start_rdy),
        .start_val(start_val),
        .start_gap(start_gap),
        .IN       (IN),
        .latch    (latch),
        .dec      (dec),
        .zero     (zero),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // Behavioural loadable down-counter with a registered zero flag.
    always @(posedge clk or posedge rst) begin
        if (rst) ctr_q <= 4'd0;
        else if (latch) ctr_q <= IN;
        else if (dec && ctr_q != 4'd0) ctr_q <= ctr_q - 4'd1;
    end
    assign zero = stuck ? 1'b0 : (ctr_q == 4'd0);

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({latch, dec, done, err, busy} !== 5'b00000 || IN !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got l/d/dn/e/b=%b IN=%0d exp 00000 IN=0", {latch, dec, done, err, busy}, IN);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (start_rdy !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle got rdy=%b busy=%b exp rdy=1 busy=0", start_rdy, busy);
        end
    endtask

    // Runs one command from an IDLE sample point and ends at the IDLE sample
    // point of cycle D+1. With hold, start_vld stays high throughout and the
    // next command's fields are presented from cycle D+1 onward.
    task automatic run_command(input int n, input int g, input bit hold, input int nn, input int ng);
        int  d;
        bit  e_l, e_d, e_dn;
        d = 4 + n * (g + 3);
        n_tests++;
        if (start_rdy !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cmd_entry_idle n=%0d g=%0d got rdy=%b busy=%b exp rdy=1 busy=0", n, g, start_rdy, busy);
        end
        start_vld = 1'b1;
        start_val = 4'(n);
        start_gap = 4'(g);
        for (int c = 1; c <= d; c++) begin
            @(posedge clk); #1;
            e_l  = (c == 1);
            e_d  = (c > 1) && (((c - 1) % (g + 3)) == 0) && (((c - 1) / (g + 3)) <= n);
            e_dn = (c == d);
            n_tests++;
            if ({latch, dec, done, err, busy, start_rdy} !== {e_l, e_d, e_dn, 1'b0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL cmd_strobes n=%0d g=%0d c=%0d got l/d/dn/e/b/r=%b exp=%b", n, g, c,
                         {latch, dec, done, err, busy, start_rdy}, {e_l, e_d, e_dn, 1'b0, 1'b1, 1'b0});
            end
            n_tests++;
            if (IN !== 4'(n)) begin
                n_fail++;
                $display("FAIL cmd_IN n=%0d c=%0d got=%0d exp=%0d", n, c, IN, n);
            end
            if (hold) begin
                start_vld = 1'b1;
                start_val = (c == d) ? 4'(nn) : 4'($urandom);
                start_gap = (c == d) ? 4'(ng) : 4'($urandom);
            end else begin
                start_vld = (c == d) ? 1'b0 : 1'($urandom_range(0, 1));
                start_val = 4'($urandom);
                start_gap = 4'($urandom);
            end
        end
        @(posedge clk); #1;
        n_tests++;
        if ({latch, dec, done, err, busy, start_rdy} !== 6'b000001) begin
            n_fail++;
            $display("FAIL cmd_after_done n=%0d g=%0d got l/d/dn/e/b/r=%b exp=000001", n, g,
                     {latch, dec, done, err, busy, start_rdy});
        end
    endtask

    task automatic test_directed();
        run_command(14, 0, 1'b0, 0, 0);
        run_command(3, 2, 1'b0, 0, 0);
        run_command(0, 5, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_command(2, 1, 1'b1, 5, 0);
        run_command(5, 0, 1'b1, 1, 3);
        run_command(1, 3, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_command(int'($urandom_range(0, 15)), int'($urandom_range(0, 4)), 1'b0, 0, 0);
        end
    endtask

    task automatic test_reset_mid_gap();
        start_vld = 1'b1;
        start_val = 4'd3;
        start_gap = 4'd5;
        @(posedge clk); #1;
        start_vld = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        // now in cycle 5, inside the gap (cycles 4..8)
        n_tests++;
        if (busy !== 1'b1 || dec !== 1'b0) begin
            n_fail++;
            $display("FAIL midgap_precheck got busy=%b dec=%b exp busy=1 dec=0", busy, dec);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({latch, dec, done, err, busy} !== 5'b00000 || IN !== 4'd0) begin
            n_fail++;
            $display("FAIL midgap_async_reset got l/d/dn/e/b=%b IN=%0d exp 00000 IN=0", {latch, dec, done, err, busy}, IN);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            n_tests++;
            if ({latch, dec, done, err, busy, start_rdy} !== 6'b000001) begin
                n_fail++;
                $display("FAIL midgap_after_release c=%0d got l/d/dn/e/b/r=%b exp=000001", c,
                         {latch, dec, done, err, busy, start_rdy});
            end
        end
    endtask

    task automatic test_overrun();
        int g, lim;
        bit macro_on, e_l, e_d, e_er;
        g = int'($urandom_range(0, 3));
`ifdef CMD_OVERRUN_CHECK_EN
        macro_on = 1'b1;
        lim = 1 + 3 * (g + 3);
`else
        macro_on = 1'b0;
        lim = 40;
`endif
        stuck     = 1'b1;
        start_vld = 1'b1;
        start_val = 4'd2;
        start_gap = 4'(g);
        for (int c = 1; c <= lim; c++) begin
            @(posedge clk); #1;
            start_vld = 1'b0;
            e_l  = (c == 1);
            e_d  = (c > 1) && (((c - 1) % (g + 3)) == 0) && (!macro_on || (((c - 1) / (g + 3)) <= 2));
            e_er = macro_on && (c == lim);
            n_tests++;
            if ({latch, dec, done, err, busy} !== {e_l, e_d, 1'b0, e_er, 1'b1}) begin
                n_fail++;
                $display("FAIL overrun g=%0d c=%0d got l/d/dn/e/b=%b exp=%b", g, c,
                         {latch, dec, done, err, busy}, {e_l, e_d, 1'b0, e_er, 1'b1});
            end
        end
        if (macro_on) begin
            @(posedge clk); #1;
            n_tests++;
            if ({done, err, busy, start_rdy} !== 4'b0001) begin
                n_fail++;
                $display("FAIL overrun_exit got dn/e/b/r=%b exp=0001", {done, err, busy, start_rdy});
            end
        end else begin
            #2 rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk); #1;
        end
        stuck = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid_gap();
        run_command(1, 0, 1'b0, 0, 0);
        test_overrun();
        run_command(2, 2, 1'b0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
